// File: rtl/circuito_d_pkg.sv
// Shared constants for circuito_d: counter sizing and the {s1,s2} truth table indexed by {a,b,c}.
package circuito_d_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // {s1,s2} for abc = 000 .. 111
    localparam logic [1:0] TRUTH_TBL [8] = '{
        2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11
    };

endpackage

// File: rtl/circuito_d_core.sv
// Combinational full-adder core: majority (carry) and odd parity (sum) of three bits.
module circuito_d_core (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic maj,
    output logic par
);

    assign maj = (a & b) | (a & c) | (b & c);
    assign par = a ^ b ^ c;

endmodule

// File: rtl/circuito_d.sv
// Registered 1-bit full adder; defining CIRCUITO_D_CNT_EN adds an 8-bit saturating count of cycles with s1=1.
module circuito_d
    import circuito_d_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s1,
    output logic s2
`ifdef CIRCUITO_D_CNT_EN
    ,
    output logic [CNT_W-1:0] s1_cnt
`endif
);

    logic maj;
    logic par;

    circuito_d_core u_core (
        .a   (a),
        .b   (b),
        .c   (c),
        .maj (maj),
        .par (par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= maj;
            s2 <= par;
        end
    end

`ifdef CIRCUITO_D_CNT_EN
    // Counts the already-registered s1, so it trails s1 by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cnt <= '0;
        end else if (s1 && (s1_cnt != CNT_MAX)) begin
            s1_cnt <= s1_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_circuito_d.sv
// Self-checking bench for circuito_d: directed sweeps plus random stimulus against an arithmetic full-adder model.
`timescale 1ns/1ps
module tb_circuito_d;
    import circuito_d_pkg::*;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic s1;
    logic s2;
`ifdef CIRCUITO_D_CNT_EN
    logic [CNT_W-1:0] s1_cnt;
`endif

    int n_vec;
    int n_err;

    // Reference state: what the outputs should hold after the latest edge.
    logic exp_s1;
    logic exp_s2;
    int   exp_cnt;

    circuito_d dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .s1  (s1),
        .s2  (s2)
`ifdef CIRCUITO_D_CNT_EN
        ,
        .s1_cnt (s1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".s1"}, 8'(s1), 8'(exp_s1));
        check({tag, ".s2"}, 8'(s2), 8'(exp_s2));
`ifdef CIRCUITO_D_CNT_EN
        check({tag, ".cnt"}, s1_cnt, 8'(exp_cnt));
`endif
    endtask

    // Apply one vector across one edge and advance the model from the count of ones.
    task automatic cycle(input logic ia, input logic ib, input logic ic, input logic irst);
        int ones;
        a = ia;
        b = ib;
        c = ic;
        rst = irst;
        @(posedge clk);
        if (irst) begin
            exp_s1 = 1'b0;
            exp_s2 = 1'b0;
            exp_cnt = 0;
        end else begin
            if (exp_s1 && exp_cnt < int'(CNT_MAX)) exp_cnt = exp_cnt + 1;
            ones = int'(ia) + int'(ib) + int'(ic);
            exp_s1 = (ones >= 2);
            exp_s2 = (ones % 2) == 1;
        end
        #1;
    endtask

    initial begin
        logic [2:0] v;
        n_vec = 0;
        n_err = 0;
        exp_s1 = 1'b0;
        exp_s2 = 1'b0;
        exp_cnt = 0;
        a = 1'b1; b = 1'b1; c = 1'b1; rst = 1'b1;

        // Reset held two cycles with all inputs high.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check_outputs("reset");

        // Exhaustive sweep, checked against the package truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            cycle(v[2], v[1], v[0], 1'b0);
            check("sweep.s1", 8'(s1), 8'(TRUTH_TBL[i][1]));
            check("sweep.s2", 8'(s2), 8'(TRUTH_TBL[i][0]));
            check_outputs("sweep");
        end

        // Latency: new inputs must not show before the next edge.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        a = 1'b1; b = 1'b1; c = 1'b1;
        #2;
        check("lat_pre.s1", 8'(s1), 8'd0);
        check("lat_pre.s2", 8'(s2), 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("lat_post.s1", 8'(s1), 8'd1);
        check("lat_post.s2", 8'(s2), 8'd1);

        // Mid-stream reset with steady 111.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("midrst.s1", 8'(s1), 8'd0);
        check_outputs("midrst");
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("after_rst.s1", 8'(s1), 8'd1);
        check_outputs("after_rst");

        // Saturation run (also plain s1/s2 checks in the default build).
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            check_outputs("sat");
        end
`ifdef CIRCUITO_D_CNT_EN
        check("sat_final", s1_cnt, CNT_MAX);
`endif
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_outputs("sat_rst");

        // Idle: parity high, majority low, counter must stay at zero.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            check_outputs("idle");
        end

        // Random vectors with occasional resets.
        for (int i = 0; i < 400; i++) begin
            v = 3'($urandom_range(0, 7));
            cycle(v[2], v[1], v[0], ($urandom_range(0, 15) == 0));
            check_outputs("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
